// File: rtl/bcd_pkg.sv
// Shared BCD constants and the serial-controller state encoding used by the
// adder- and subtractor-side datapath blocks.
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam int unsigned BCD_MAX     = 9;
  localparam int unsigned BCD_ADJ     = 6;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } bcd_state_t;

endpackage

// File: rtl/bcd_digit_sub.sv
// Single BCD digit subtract with borrow; a borrow-out raw result is pulled
// back into the 0..9 range by subtracting 6 modulo 16.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] a,
  input  logic [BCD_DIGIT_W-1:0] b,
  input  logic                   bin,
  output logic [BCD_DIGIT_W-1:0] d,
  output logic                   bout
);

  logic [BCD_DIGIT_W:0] raw;

  always_comb begin
    raw  = {1'b0, a} - {1'b0, b} - {{BCD_DIGIT_W{1'b0}}, bin};
    bout = raw[BCD_DIGIT_W];
    if (raw[BCD_DIGIT_W]) begin
      d = raw[BCD_DIGIT_W-1:0] - BCD_DIGIT_W'(BCD_ADJ);
    end else begin
      d = raw[BCD_DIGIT_W-1:0];
    end
  end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial N-digit BCD subtractor, LSD first, with a start/done handshake.
// Operands are captured on an accepted start and consumed one digit per cycle.
module bcd_serial_subtractor
  import bcd_pkg::*;
#(
  parameter int unsigned N_DIGITS = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [N_DIGITS*BCD_DIGIT_W-1:0] a_bcd,
  input  logic [N_DIGITS*BCD_DIGIT_W-1:0] b_bcd,
  output logic                            busy,
  output logic                            done,
  output logic [N_DIGITS*BCD_DIGIT_W-1:0] diff_bcd,
  output logic                            neg,
  output logic                            err
);

  localparam int unsigned W     = N_DIGITS * BCD_DIGIT_W;
  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  bcd_state_t             state;
  logic [W-1:0]           a_sh;
  logic [W-1:0]           b_sh;
  logic [IDX_W-1:0]       idx;
  logic                   borrow;
  logic                   bad_digit;
  logic [BCD_DIGIT_W-1:0] digit;
  logic                   borrow_next;

  bcd_digit_sub u_digit (
    .a    (a_sh[BCD_DIGIT_W-1:0]),
    .b    (b_sh[BCD_DIGIT_W-1:0]),
    .bin  (borrow),
    .d    (digit),
    .bout (borrow_next)
  );

  always_comb begin
    bad_digit = 1'b0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (a_bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_DIGIT_W'(BCD_MAX) ||
          b_bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_DIGIT_W'(BCD_MAX)) begin
        bad_digit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      idx      <= '0;
      borrow   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      diff_bcd <= '0;
      neg      <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state    <= RUN;
            a_sh     <= a_bcd;
            b_sh     <= b_bcd;
            idx      <= '0;
            borrow   <= 1'b0;
            busy     <= 1'b1;
            diff_bcd <= '0;
            neg      <= 1'b0;
            err      <= bad_digit;
          end
        end
        RUN: begin
          // New digit enters at the MSD end so digit i lands at [4i+3:4i] after N shifts.
          diff_bcd <= (diff_bcd >> BCD_DIGIT_W) | (W'(digit) << (W - BCD_DIGIT_W));
          a_sh     <= a_sh >> BCD_DIGIT_W;
          b_sh     <= b_sh >> BCD_DIGIT_W;
          borrow   <= borrow_next;
          idx      <= idx + 1'b1;
          if (idx == IDX_W'(N_DIGITS - 1)) begin
            state <= DONE;
            done  <= 1'b1;
            neg   <= borrow_next;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Directed bench for the 4-digit serial BCD subtractor: handshake timing,
// borrow ripple, negative results, invalid digits, ignored starts and reset abort.
module tb_bcd_serial_subtractor;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a_bcd;
  logic [15:0] b_bcd;
  logic        busy;
  logic        done;
  logic [15:0] diff_bcd;
  logic        neg;
  logic        err;

  int unsigned checks;
  int unsigned errors;

  bcd_serial_subtractor #(.N_DIGITS(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a_bcd    (a_bcd),
    .b_bcd    (b_bcd),
    .busy     (busy),
    .done     (done),
    .diff_bcd (diff_bcd),
    .neg      (neg),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle, then wait (bounded) for done; returns the cycle it arrived in.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, output int unsigned cyc);
    cyc = 0;
    @(negedge clk);
    a_bcd = a;
    b_bcd = b;
    start = 1'b1;
    for (int unsigned k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic expect_result(input string tag, input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] d, input logic n, input logic e);
    int unsigned cyc;
    run_op(a, b, cyc);
    check({tag, "_latency"}, cyc, 5);
    check({tag, "_diff"}, diff_bcd, d);
    check({tag, "_neg"}, neg, n);
    check({tag, "_err"}, err, e);
  endtask

  initial begin
    int unsigned cyc;
    int unsigned done_cnt;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    a_bcd  = '0;
    b_bcd  = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff_bcd, 0);
    check("rst_neg", neg, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: busy in cycles 1-5, done in cycle 5
    a_bcd = 16'h0042;
    b_bcd = 16'h0017;
    start = 1'b1;
    cyc   = 0;
    for (int unsigned k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k <= 5) check($sformatf("t1_busy_c%0d", k), busy, 1);
      if (k < 5) check($sformatf("t1_nodone_c%0d", k), done, 0);
      if (done) begin
        cyc = k;
        break;
      end
    end
    check("t1_latency", cyc, 5);
    check("t1_diff", diff_bcd, 16'h0025);
    check("t1_neg", neg, 0);
    check("t1_err", err, 0);
    @(negedge clk);
    check("t1_idle_busy", busy, 0);
    check("t1_idle_done", done, 0);
    check("t1_hold_diff", diff_bcd, 16'h0025);

    // 2, 3: borrow ripple and 10's-complement results
    expect_result("t2", 16'h1000, 16'h0001, 16'h0999, 1'b0, 1'b0);
    expect_result("t3a", 16'h0000, 16'h0001, 16'h9999, 1'b1, 1'b0);
    expect_result("t3b", 16'h9999, 16'h9999, 16'h0000, 1'b0, 1'b0);
    expect_result("t3c", 16'h0500, 16'h0123, 16'h0377, 1'b0, 1'b0);

    // 4: starts in cycles 2 (RUN) and 5 (DONE) are ignored
    @(negedge clk);
    a_bcd = 16'h0042;
    b_bcd = 16'h0017;
    start = 1'b1;
    done_cnt = 0;
    for (int unsigned k = 1; k <= 12; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 2 || k == 5) begin
        a_bcd = 16'h8888;
        b_bcd = 16'h1111;
        start = 1'b1;
      end
      if (done) begin
        done_cnt++;
        check("t4_done_cycle", k, 5);
      end
    end
    check("t4_done_count", done_cnt, 1);
    check("t4_diff", diff_bcd, 16'h0025);
    check("t4_busy", busy, 0);

    // 5: invalid digit flags err; next valid start clears it
    expect_result("t5a", 16'h00A3, 16'h0001, 16'h00A2, 1'b0, 1'b1);
    @(negedge clk);
    check("t5_err_held", err, 1);
    expect_result("t5b", 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0);

    // 6: reset during RUN aborts without a done pulse
    @(negedge clk);
    a_bcd = 16'h0042;
    b_bcd = 16'h0017;
    start = 1'b1;
    done_cnt = 0;
    for (int unsigned k = 1; k <= 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) done_cnt++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_busy", busy, 0);
    check("t6_diff", diff_bcd, 0);
    check("t6_done", done, 0);
    rst_n = 1'b1;
    for (int unsigned k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("t6_no_done", done_cnt, 0);
    expect_result("t6b", 16'h0100, 16'h0099, 16'h0001, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
